// File: rtl/mult_shift_add.sv
// mult_shift_add: sequential shift-and-add multiplier giving a 2n-bit signed or unsigned product
module mult_shift_add #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e,
    input  logic         read,
    input  logic         sgn,
    input  logic [n-1:0] dataA,
    input  logic [n-1:0] dataB,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo,
    output logic         done
);
    localparam int CW = $clog2(n + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q, state_d;
    logic [n-1:0] hi_q, hi_d, lo_q, lo_d, mag_q, mag_d, abs_a, abs_b;
    logic [CW-1:0] cnt_q, cnt_d;
    logic neg_q, neg_d, done_q, done_d;
    logic [n:0] sum;
    logic [2*n-1:0] prod_neg;
    always_comb begin
        abs_a = (sgn && dataA[n-1]) ? -dataA : dataA;
        abs_b = (sgn && dataB[n-1]) ? -dataB : dataB;
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        prod_neg = -{hi_q, lo_q};
        state_d = state_q;
        hi_d = hi_q;
        lo_d = lo_q;
        mag_d = mag_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        done_d = done_q;
        if (read) begin
            hi_d = '0;
            lo_d = abs_b;
            mag_d = abs_a;
            neg_d = sgn & (dataA[n-1] ^ dataB[n-1]);
            cnt_d = '0;
            done_d = 1'b0;
            state_d = CALC;
        end else if (e && state_q == CALC) begin
            hi_d = sum[n:1];
            lo_d = {sum[0], lo_q[n-1:1]};
            cnt_d = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(n - 1)) ? FIX : CALC;
        end else if (e && state_q == FIX) begin
            {hi_d, lo_d} = neg_q ? prod_neg : {hi_q, lo_q};
            done_d = 1'b1;
            state_d = DONE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q <= '0;
            lo_q <= '0;
            mag_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            mag_q <= mag_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
            done_q <= done_d;
        end
    end
    assign hi = hi_q;
    assign lo = lo_q;
    assign done = done_q;
endmodule
